// File: rtl/m_prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package m_prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        RUN,
        ERR
    } ldr_state_e;

    localparam logic [7:0] HDR_BYTE   = 8'hA5;
    localparam int         LDR_ADDR_W = 12;
    localparam logic [16:0] MAX_LEN   = 17'd1 << LDR_ADDR_W;

    // Largest legal word count for a memory of 2^addr_w words.
    function automatic logic [16:0] max_len(input int addr_w);
        return 17'd1 << addr_w;
    endfunction

endpackage

// File: rtl/m_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; word_done_o fires
// combinationally with the strobe of every 4th byte.
module m_byte_packer (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        clr_i,
    input  logic        strobe_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]  cnt_q, cnt_d;
    // Only the first three bytes need storing; the fourth is taken live.
    logic [23:0] sr_q, sr_d;

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clr_i) begin
            cnt_d = 2'd0;
            sr_d  = 24'd0;
        end else if (strobe_i) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {byte_i, sr_q[23:8]};
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            cnt_q <= 2'd0;
            sr_q  <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    assign word_o      = {byte_i, sr_q};
    assign word_done_o = strobe_i && (cnt_q == 2'd3);

endmodule

// File: rtl/m_prog_loader.sv
// Framed byte-stream loader for the instruction memory; releases the processor
// once a full frame is stored. Define LOADER_CSUM_EN to expect a checksum byte.
module m_prog_loader
    import m_prog_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_rx_valid,
    input  logic [7:0]        w_rx_data,
    output logic              w_rx_ready,
    output logic              w_imem_we,
    output logic [ADDR_W-1:0] w_imem_addr,
    output logic [DATA_W-1:0] w_imem_wdata,
    output logic              w_proc_ce,
    output logic              w_busy,
    output logic              w_err
);

    ldr_state_e        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [16:0]       cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ce_q, ce_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
`ifdef LOADER_CSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic        xfer;
    logic        pk_clr, pk_stb, pk_done;
    logic [31:0] pk_word;
    logic [15:0] len_full;

    assign xfer     = w_rx_valid && ready_q;
    assign len_full = {w_rx_data, len_q[7:0]};

    m_byte_packer u_packer (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .clr_i       (pk_clr),
        .strobe_i    (pk_stb),
        .byte_i      (w_rx_data),
        .word_o      (pk_word),
        .word_done_o (pk_done)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pk_clr  = 1'b0;
        pk_stb  = 1'b0;
`ifdef LOADER_CSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (xfer && w_rx_data == HDR_BYTE) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = w_rx_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == 16'd0 || {1'b0, len_full} > max_len(ADDR_W)) begin
                        state_d = ERR;
                    end else begin
                        cnt_d   = 17'd0;
                        last_d  = 1'b0;
                        pk_clr  = 1'b1;
`ifdef LOADER_CSUM_EN
                        sum_d   = 8'd0;
`endif
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    pk_stb = 1'b1;
`ifdef LOADER_CSUM_EN
                    sum_d  = sum_q + w_rx_data;
`endif
                    if (pk_done) begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = pk_word;
                        cnt_d   = cnt_q + 17'd1;
                        last_d  = (cnt_q + 17'd1) == {1'b0, len_q};
                    end
                end else if (we_q && last_q) begin
                    // Frame body ends on the write cycle of the final word.
`ifdef LOADER_CSUM_EN
                    state_d = CSUM;
`else
                    state_d = RUN;
`endif
                end
            end
`ifdef LOADER_CSUM_EN
            CSUM: begin
                if (xfer) state_d = (8'(sum_q + w_rx_data) == 8'd0) ? RUN : ERR;
            end
`endif
            RUN, ERR: begin
                if (xfer && w_rx_data == HDR_BYTE) state_d = LEN_LO;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change one cycle
    // after the byte that caused them.
    assign ready_d = !(pk_stb && pk_done);
    assign ce_d    = (state_d == RUN);
    assign err_d   = (state_d == ERR);
    assign busy_d  = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                     (state_d == DATA)   || (state_d == CSUM);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= IDLE;
            len_q   <= 16'd0;
            cnt_q   <= 17'd0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ce_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CSUM_EN
            sum_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ce_q    <= ce_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef LOADER_CSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign w_rx_ready   = ready_q;
    assign w_imem_we    = we_q;
    assign w_imem_addr  = addr_q;
    assign w_imem_wdata = wdata_q;
    assign w_proc_ce    = ce_q;
    assign w_busy       = busy_q;
    assign w_err        = err_q;

endmodule

// File: tb/tb_m_prog_loader.sv
// Self-checking bench for m_prog_loader; follows LOADER_CSUM_EN if defined.
module tb_m_prog_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
`ifdef LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              w_clk = 1'b0;
    logic              w_rst_n = 1'b0;
    logic              w_rx_valid = 1'b0;
    logic [7:0]        w_rx_data = 8'd0;
    logic              w_rx_ready;
    logic              w_imem_we;
    logic [ADDR_W-1:0] w_imem_addr;
    logic [DATA_W-1:0] w_imem_wdata;
    logic              w_proc_ce;
    logic              w_busy;
    logic              w_err;

    m_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .w_clk        (w_clk),
        .w_rst_n      (w_rst_n),
        .w_rx_valid   (w_rx_valid),
        .w_rx_data    (w_rx_data),
        .w_rx_ready   (w_rx_ready),
        .w_imem_we    (w_imem_we),
        .w_imem_addr  (w_imem_addr),
        .w_imem_wdata (w_imem_wdata),
        .w_proc_ce    (w_proc_ce),
        .w_busy       (w_busy),
        .w_err        (w_err)
    );

    always #5 w_clk = ~w_clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] word;
        int          delta;
        logic        exp_ce;
        logic        exp_err;
    } vec_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    vec_t        vecs[5];
    logic [31:0] fw[8];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          wr_cnt = 0;
    int          ready_low = 0;
    logic        prev_we = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // Present one byte and hold it until the handshake completes.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        w_rx_valid = 1'b1;
        w_rx_data  = b;
        while (!w_rx_ready && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) begin
            chk_cnt++;
            $display("FAIL send_timeout: byte 0x%02h not accepted, ready=%0b required 1", b, w_rx_ready);
            w_rx_valid = 1'b0;
        end else begin
            tick();
        end
    endtask

    // Length, data and (if enabled) checksum; sum+checksum equals delta.
    task automatic send_body(input logic [15:0] n, input int delta);
        logic [7:0] sum;
        logic [7:0] bt;
        sum = 8'd0;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int w = 0; w < int'(n); w++) begin
            exp_q.push_back({12'(w), fw[w]});
            for (int b = 0; b < 4; b++) begin
                bt  = fw[w][8*b +: 8];
                sum = sum + bt;
                send_byte(bt);
            end
        end
        if (CSUM_EN) send_byte(8'(8'd0 - sum + 8'(delta)));
        w_rx_valid = 1'b0;
    endtask

    // After send_body: without a checksum we sit in the last write cycle.
    task automatic settle();
        if (!CSUM_EN) begin
            check("last_write_ce_low", 64'(w_proc_ce), 64'd0);
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 64'({w_rx_ready, w_imem_we, w_imem_addr, w_imem_wdata, w_proc_ce, w_busy, w_err}), 64'd0);
    endtask

    always @(negedge w_clk) begin
        if (w_rst_n && !w_rx_ready) ready_low++;
        if (w_imem_we) begin
            wr_cnt++;
            check("we_ready_bubble", 64'(w_rx_ready), 64'd0);
            check("we_single_cycle", 64'(prev_we), 64'd0);
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, none expected", w_imem_addr, w_imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(w_imem_addr), 64'(mon_e.addr));
                check("wr_data", 64'(w_imem_wdata), 64'(mon_e.data));
                $display("write addr=0x%03h data=0x%08h", w_imem_addr, w_imem_wdata);
            end
        end
        prev_we = w_imem_we;
    end

    initial begin
        int c0;
        logic [15:0] bad_len[2];

        vecs[0] = '{word: 32'h0000_0013, delta: 0, exp_ce: 1'b1, exp_err: 1'b0};
        vecs[1] = '{word: 32'hDEAD_BEEF, delta: 0, exp_ce: 1'b1, exp_err: 1'b0};
        vecs[2] = '{word: 32'h1234_5678, delta: 1, exp_ce: !CSUM_EN, exp_err: CSUM_EN};
        vecs[3] = '{word: 32'hFFFF_FFFF, delta: 0, exp_ce: 1'b1, exp_err: 1'b0};
        vecs[4] = '{word: 32'h8000_0001, delta: 0, exp_ce: 1'b1, exp_err: 1'b0};
        bad_len[0] = 16'h0000;
        bad_len[1] = 16'h1001;

        repeat (3) tick();
        check_reset_outputs("reset_outputs");
        w_rst_n = 1'b1;
        check("ready_low_before_edge", 64'(w_rx_ready), 64'd0);
        tick();
        check("ready_rise", 64'(w_rx_ready), 64'd1);

        // Single-word frames from IDLE, RUN and ERR.
        for (int i = 0; i < 5; i++) begin
            send_byte(8'hA5);
            w_rx_valid = 1'b0;
            check("hdr_ce_low", 64'(w_proc_ce), 64'd0);
            check("hdr_busy", 64'(w_busy), 64'd1);
            check("hdr_err_clear", 64'(w_err), 64'd0);
            fw[0] = vecs[i].word;
            send_body(16'd1, vecs[i].delta);
            settle();
            check("vec_ce", 64'(w_proc_ce), 64'(vecs[i].exp_ce));
            check("vec_err", 64'(w_err), 64'(vecs[i].exp_err));
            check("vec_busy_done", 64'(w_busy), 64'd0);
            $display("frame %0d word=0x%08h ce=%0b err=%0b", i, vecs[i].word, w_proc_ce, w_err);
            repeat (2) tick();
        end

        // Three words streamed back-to-back.
        fw[0] = 32'h0302_0100;
        fw[1] = 32'hA1B2_C3D4;
        fw[2] = 32'h0BAD_F00D;
        c0 = ready_low;
        send_byte(8'hA5);
        send_body(16'd3, 0);
        settle();
        check("n3_ce", 64'(w_proc_ce), 64'd1);
        tick();
        check("n3_ready_bubbles", 64'(ready_low - c0), 64'd3);

        // Illegal lengths.
        for (int i = 0; i < 2; i++) begin
            c0 = wr_cnt;
            send_byte(8'hA5);
            send_byte(bad_len[i][7:0]);
            send_byte(bad_len[i][15:8]);
            w_rx_valid = 1'b0;
            check("badlen_err", 64'(w_err), 64'd1);
            check("badlen_ce", 64'(w_proc_ce), 64'd0);
            check("badlen_busy", 64'(w_busy), 64'd0);
            repeat (4) tick();
            check("badlen_no_write", 64'(wr_cnt - c0), 64'd0);
            $display("bad length 0x%04h err=%0b", bad_len[i], w_err);
        end

        fw[0] = 32'h0000_0013;
        send_byte(8'hA5);
        send_body(16'd1, 0);
        settle();
        check("recover_ce", 64'(w_proc_ce), 64'd1);
        check("recover_err", 64'(w_err), 64'd0);

        // Maximum legal length accepted, then reset mid-word.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        w_rx_valid = 1'b0;
        check("maxlen_busy", 64'(w_busy), 64'd1);
        check("maxlen_err", 64'(w_err), 64'd0);
        c0 = wr_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        w_rx_valid = 1'b0;
        #2 w_rst_n = 1'b0;
        #1 check_reset_outputs("async_reset_outputs");
        repeat (2) tick();
        w_rst_n = 1'b1;
        tick();
        check("post_reset_no_write", 64'(wr_cnt - c0), 64'd0);
        check("post_reset_ce", 64'(w_proc_ce), 64'd0);
        check("post_reset_ready", 64'(w_rx_ready), 64'd1);

        fw[0] = 32'hCAFE_F00D;
        send_byte(8'hA5);
        send_body(16'd1, 0);
        settle();
        check("final_ce", 64'(w_proc_ce), 64'd1);

        repeat (3) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
